// File: rtl/dem_tree_sequencer.sv
// Tree DEM sequencer: splits one clamped code across NUM_LAYERS binary layers, one layer per clock,
// steering odd remainders by LFSR (random) or per-node parity (rotate), then presents the leaf enables.
module dem_tree_sequencer #(
  parameter int          OUTPUT_WIDTH = 3,
  parameter int          NUM_LAYERS   = 3,
  parameter logic [7:0]  LFSR_INIT    = 8'hFF,
  localparam int         N            = 1 << NUM_LAYERS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OUTPUT_WIDTH-1:0] in_code,
  input  logic                    mode_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_elem,
  output logic                    out_sat,
  output logic                    busy
);

  localparam int CW = NUM_LAYERS + 1;
  localparam int XW = (OUTPUT_WIDTH > CW) ? OUTPUT_WIDTH : CW;
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int NN = (N / 2 > 0) ? N / 2 : 1;

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           l_q, l_d;
  logic [NN-1:0][CW-1:0]   cnt_q, cnt_d;
  logic [N-2:0]            parity_q, parity_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic                    mode_q, mode_d;
  logic                    sat_q, sat_d;
  logic [N-1:0]            out_elem_q, out_elem_d;
  logic                    out_sat_q, out_sat_d;
  logic [XW-1:0]           code_ext;
  logic [CW-1:0]           c, left, right;
  logic                    odd, steer;

  always_comb begin
    state_d    = state_q;
    l_d        = l_q;
    cnt_d      = cnt_q;
    parity_d   = parity_q;
    lfsr_d     = lfsr_q;
    mode_d     = mode_q;
    sat_d      = sat_q;
    out_elem_d = out_elem_q;
    out_sat_d  = out_sat_q;
    code_ext   = XW'(in_code);
    c          = '0;
    left       = '0;
    right      = '0;
    odd        = 1'b0;
    steer      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sat_d    = code_ext > XW'(N);
          cnt_d    = '0;
          cnt_d[0] = sat_d ? CW'(N) : CW'(code_ext);
          mode_d   = mode_sel;
          l_d      = '0;
          state_d  = SPLIT;
        end
      end
      SPLIT: begin
        // Only the nodes of the current layer are active; leaves go straight to the output register.
        for (int l = 0; l < NUM_LAYERS; l++) begin
          for (int k = 0; k < (1 << l); k++) begin
            if (l_q == LW'(l)) begin
              c     = cnt_q[k];
              odd   = c[0];
              steer = mode_q ? ~parity_q[(1 << l) - 1 + k] : lfsr_q[k % 8];
              left  = (c >> 1) + CW'(odd & steer);
              right = (c >> 1) + CW'(odd & ~steer);
              if (mode_q && odd) begin
                parity_d[(1 << l) - 1 + k] = ~parity_q[(1 << l) - 1 + k];
              end
              if (l == NUM_LAYERS - 1) begin
                out_elem_d[2*k]   = left[0];
                out_elem_d[2*k+1] = right[0];
              end else begin
                cnt_d[(2*k) % NN]   = left;
                cnt_d[(2*k+1) % NN] = right;
              end
            end
          end
        end
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5]};
        if (l_q == LW'(NUM_LAYERS - 1)) begin
          out_sat_d = sat_q;
          state_d   = DONE;
        end else begin
          l_d = l_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      l_q        <= '0;
      cnt_q      <= '0;
      parity_q   <= '0;
      lfsr_q     <= LFSR_INIT;
      mode_q     <= 1'b0;
      sat_q      <= 1'b0;
      out_elem_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      cnt_q      <= cnt_d;
      parity_q   <= parity_d;
      lfsr_q     <= lfsr_d;
      mode_q     <= mode_d;
      sat_q      <= sat_d;
      out_elem_q <= out_elem_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_elem  = out_elem_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dem_tree_sequencer.sv
// Directed bench for dem_tree_sequencer; a second instance with a 4-bit code exercises clamping.
module tb_dem_tree_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, mode_sel, out_valid, out_ready, out_sat, busy;
  logic [2:0] in_code;
  logic [7:0] out_elem;

  logic       in_valid4, in_ready4, mode_sel4, out_valid4, out_ready4, out_sat4, busy4;
  logic [3:0] in_code4;
  logic [7:0] out_elem4;

  int nvec = 0;
  int nerr = 0;

  dem_tree_sequencer #(.OUTPUT_WIDTH(3), .NUM_LAYERS(3), .LFSR_INIT(8'hFF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .mode_sel(mode_sel), .out_valid(out_valid), .out_ready(out_ready), .out_elem(out_elem),
    .out_sat(out_sat), .busy(busy)
  );

  dem_tree_sequencer #(.OUTPUT_WIDTH(4), .NUM_LAYERS(3), .LFSR_INIT(8'hFF)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_code(in_code4),
    .mode_sel(mode_sel4), .out_valid(out_valid4), .out_ready(out_ready4), .out_elem(out_elem4),
    .out_sat(out_sat4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Stimulus only: offers one code, waits for out_valid, captures results.
  task automatic send(input logic [2:0] code, input logic mode, output logic [7:0] elem,
                      output logic sat, output int lat, output logic [7:0] lfsr_done);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    in_code = code; mode_sel = mode; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    elem = out_elem; sat = out_sat; lfsr_done = dut.lfsr_q;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (in_ready !== 1'b1)     begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    nvec++; if (out_valid !== 1'b0)    begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (out_elem !== 8'h00)    begin nerr++; $display("FAIL reset_out_elem got %h want 00", out_elem); end
    nvec++; if (out_sat !== 1'b0)      begin nerr++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
    nvec++; if (busy !== 1'b0)         begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (dut.lfsr_q !== 8'hFF)  begin nerr++; $display("FAIL reset_lfsr got %h want ff", dut.lfsr_q); end
  endtask

  task automatic test_random_first();
    logic [7:0] e, lf; logic s; int lat;
    do_reset();
    send(3'd5, 1'b0, e, s, lat, lf);
    nvec++; if (lat !== 3)      begin nerr++; $display("FAIL rand_latency got %0d want 3", lat); end
    nvec++; if (e !== 8'h5E)    begin nerr++; $display("FAIL rand_elem got %h want 5e", e); end
    nvec++; if (s !== 1'b0)     begin nerr++; $display("FAIL rand_sat got %b want 0", s); end
    nvec++; if (lf !== 8'hF8)   begin nerr++; $display("FAIL rand_lfsr got %h want f8", lf); end
  endtask

  task automatic test_rotate();
    logic [7:0] e, lf; logic s; int lat;
    logic [7:0] exp_rot [4];
    exp_rot = '{8'h01, 8'h10, 8'h04, 8'h40};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(3'd1, 1'b1, e, s, lat, lf);
      nvec++;
      if (lat !== 3 || e !== exp_rot[i]) begin
        nerr++; $display("FAIL rotate_%0d got elem %h lat %0d want elem %h lat 3", i, e, lat, exp_rot[i]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] e, lf; logic s; int lat;
    do_reset();
    send(3'd0, 1'b0, e, s, lat, lf);
    nvec++; if (lat !== 3 || e !== 8'h00) begin nerr++; $display("FAIL code0 got elem %h lat %0d want 00 lat 3", e, lat); end
    send(3'd7, 1'b0, e, s, lat, lf);
    nvec++; if ($countones(e) != 7) begin nerr++; $display("FAIL code7_popcount got %0d want 7", $countones(e)); end
    nvec++; if (e !== 8'hFE)        begin nerr++; $display("FAIL code7_elem got %h want fe", e); end
  endtask

  task automatic test_back_pressure();
    int lat;
    do_reset();
    out_ready = 1'b0; in_code = 3'd3; mode_sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_code = 3'd5;  // stays offered throughout the stall
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if (out_valid !== 1'b1 || out_elem !== 8'h1A || out_sat !== 1'b0 || in_ready !== 1'b0 ||
          busy !== 1'b1 || dut.lfsr_q !== 8'hF8) begin
        nerr++;
        $display("FAIL bp_hold_%0d got v%b e%h s%b ir%b b%b lfsr%h want v1 e1a s0 ir0 b1 lfsrf8",
                 i, out_valid, out_elem, out_sat, in_ready, busy, dut.lfsr_q);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL bp_release got ir%b v%b b%b want ir1 v0 b0", in_ready, out_valid, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL bp_second_accept got busy %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    nvec++;
    if (lat !== 3 || out_elem !== 8'hEA) begin
      nerr++; $display("FAIL bp_second got elem %h lat %0d want ea lat 3", out_elem, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [3:0] codes [2];
    logic       sats  [2];
    int lat;
    codes = '{4'd12, 4'd8};
    sats  = '{1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_code4 = codes[i]; mode_sel4 = 1'b0; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
      nvec++;
      if (lat !== 3 || out_elem4 !== 8'hFF || out_sat4 !== sats[i]) begin
        nerr++; $display("FAIL sat_code%0d got elem %h sat %b lat %0d want ff %b lat 3",
                         codes[i], out_elem4, out_sat4, lat, sats[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_split();
    logic [7:0] e, lf; logic s; int lat;
    do_reset();
    send(3'd1, 1'b1, e, s, lat, lf);
    nvec++; if (dut.parity_q !== 7'h0B) begin nerr++; $display("FAIL mid_parity_pre got %h want 0b", dut.parity_q); end
    in_code = 3'd5; mode_sel = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    nvec++; if (dut.l_q !== 2'd1 || busy !== 1'b1) begin nerr++; $display("FAIL mid_layer got L%0d busy %b want L1 busy 1", dut.l_q, busy); end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_elem !== 8'h00 || out_sat !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL mid_outputs got ir%b v%b e%h s%b b%b want ir1 v0 e00 s0 b0",
                       in_ready, out_valid, out_elem, out_sat, busy);
    end
    nvec++; if (dut.lfsr_q !== 8'hFF)   begin nerr++; $display("FAIL mid_lfsr got %h want ff", dut.lfsr_q); end
    nvec++; if (dut.parity_q !== 7'h00) begin nerr++; $display("FAIL mid_parity got %h want 00", dut.parity_q); end
    rst = 1'b0;
    send(3'd5, 1'b0, e, s, lat, lf);
    nvec++; if (lat !== 3 || e !== 8'h5E) begin nerr++; $display("FAIL mid_resume got elem %h lat %0d want 5e lat 3", e, lat); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_code = '0; mode_sel = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_code4 = '0; mode_sel4 = 1'b0; out_ready4 = 1'b1;
    test_reset();
    test_random_first();
    test_rotate();
    test_boundary();
    test_back_pressure();
    test_saturation();
    test_reset_mid_split();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
